// File: rtl/fir_mac_datapath_pkg.sv
// rtl/fir_mac_datapath_pkg.sv - shared widths, types and output-state encodings for the FIR MAC datapath
package fir_mac_datapath_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int ACC_WIDTH_DEF = 20;

    typedef logic signed [WIDTH_DEF-1:0]     sample_t;
    typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

    localparam logic [0:0] OUT_IDLE = 1'b0;
    localparam logic [0:0] OUT_PEND = 1'b1;

    function automatic sample_t sat_to_sample(acc_t a);
        acc_t hi;
        acc_t lo;
        hi = acc_t'((2 ** (WIDTH_DEF - 1)) - 1);
        lo = acc_t'(-(2 ** (WIDTH_DEF - 1)));
        if (a > hi)
            return {1'b0, {(WIDTH_DEF-1){1'b1}}};
        else if (a < lo)
            return {1'b1, {(WIDTH_DEF-1){1'b0}}};
        else
            return sample_t'(a);
    endfunction

endpackage

// File: rtl/fir_mac_datapath_if.sv
// rtl/fir_mac_datapath_if.sv - result output handshake between datapath and output store
interface fir_mac_datapath_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
);
    logic signed [WIDTH-1:0] wyj_dane;
    logic [AW-1:0]           wyj_adres;
    logic                    wyj_valid;
    logic                    wyj_ready;

    modport master (output wyj_dane, output wyj_adres, output wyj_valid, input wyj_ready);
    modport slave  (input wyj_dane, input wyj_adres, input wyj_valid, output wyj_ready);
endinterface

// File: rtl/fir_mac_datapath_adder.sv
// rtl/fir_mac_datapath_adder.sv - signed two's-complement adder used by the MAC accumulator
module adder #(
    parameter int WIDTH = 20
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/fir_mac_datapath.sv
// rtl/fir_mac_datapath.sv - FIR datapath: tap/sample counters, MAC accumulator, saturated result output
module fir_mac_datapath
    import fir_mac_datapath_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int N_TAPS    = 16,
    parameter int N_SAMPLES = 64,
    localparam int TW = $clog2(N_TAPS),
    localparam int SW = $clog2(N_SAMPLES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        FSM_petla_en,
    input  logic                        FSM_reset_petla,
    input  logic                        FSM_nowa_probka,
    input  logic                        FSM_reset_licznik,
    input  logic                        FSM_Acc_en,
    input  logic                        FSM_Acc_zapisz,
    input  logic                        FSM_reset_Acc,
    input  logic                        FSM_wyj_wr,
    input  logic signed [WIDTH-1:0]     mnozenie_wynik,
    output logic                        Petla_full,
    output logic                        Licznik_full,
    output logic [TW-1:0]               adres_wsp,
    output logic [SW-1:0]               adres_probki,
    output logic signed [ACC_WIDTH-1:0] Acc_out,
    output logic                        blad_overrun,
    fir_mac_datapath_if.master          wyj
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(-(2 ** (WIDTH - 1)));
    localparam logic signed [WIDTH-1:0]     OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]     OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] suma_wynik;
    logic signed [WIDTH-1:0]     sat_val;
    logic signed [WIDTH-1:0]     res_dane;
    logic [SW-1:0]               res_adres;
    logic [0:0]                  out_state;

    assign Petla_full   = (adres_wsp == TW'(N_TAPS - 1));
    assign Licznik_full = (adres_probki == SW'(N_SAMPLES - 1));
    assign prod_ext     = ACC_WIDTH'(mnozenie_wynik);
    assign wyj.wyj_valid = (out_state == OUT_PEND);

    adder #(.WIDTH(ACC_WIDTH)) u_adder (
        .a   (prod_ext),
        .b   (Acc_out),
        .sum (suma_wynik)
    );

    always_comb begin
        sat_val = Acc_out[WIDTH-1:0];
        if (Acc_out > ACC_MAX)
            sat_val = OUT_MAX;
        else if (Acc_out < ACC_MIN)
            sat_val = OUT_MIN;
    end

    // Counters saturate at their top value; the FSM is expected to clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            adres_wsp    <= '0;
            adres_probki <= '0;
        end else begin
            if (FSM_reset_petla)
                adres_wsp <= '0;
            else if (FSM_petla_en && !Petla_full)
                adres_wsp <= adres_wsp + TW'(1);

            if (FSM_reset_licznik)
                adres_probki <= '0;
            else if (FSM_nowa_probka && !Licznik_full)
                adres_probki <= adres_probki + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Acc_out   <= '0;
            res_dane  <= '0;
            res_adres <= '0;
        end else begin
            if (FSM_reset_Acc)
                Acc_out <= '0;
            else if (FSM_Acc_en)
                Acc_out <= suma_wynik;

            if (FSM_Acc_zapisz) begin
                res_dane  <= sat_val;
                res_adres <= adres_probki;
            end
        end
    end

    // A write request while the store is stalled is dropped and flagged; held data stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state     <= OUT_IDLE;
            wyj.wyj_dane  <= '0;
            wyj.wyj_adres <= '0;
            blad_overrun  <= 1'b0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (FSM_wyj_wr) begin
                        out_state     <= OUT_PEND;
                        wyj.wyj_dane  <= res_dane;
                        wyj.wyj_adres <= res_adres;
                    end
                end
                default: begin
                    if (wyj.wyj_ready) begin
                        if (FSM_wyj_wr) begin
                            wyj.wyj_dane  <= res_dane;
                            wyj.wyj_adres <= res_adres;
                        end else begin
                            out_state <= OUT_IDLE;
                        end
                    end else if (FSM_wyj_wr) begin
                        blad_overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_datapath.sv
// tb/tb_fir_mac_datapath.sv - directed self-checking bench for fir_mac_datapath
module tb_fir_mac_datapath;
    import fir_mac_datapath_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic petla_en, reset_petla, nowa_probka, reset_licznik;
    logic acc_en, acc_zapisz, reset_acc, wyj_wr;
    logic signed [15:0] mnoz;
    logic petla_full, licznik_full, overrun;
    logic [3:0] adres_wsp;
    logic [5:0] adres_probki;
    logic signed [19:0] acc_out;

    int n_tests = 0;
    int n_fail  = 0;

    fir_mac_datapath_if #(.WIDTH(16), .AW(6)) dif ();

    fir_mac_datapath #(.WIDTH(16), .ACC_WIDTH(20), .N_TAPS(16), .N_SAMPLES(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .FSM_petla_en      (petla_en),
        .FSM_reset_petla   (reset_petla),
        .FSM_nowa_probka   (nowa_probka),
        .FSM_reset_licznik (reset_licznik),
        .FSM_Acc_en        (acc_en),
        .FSM_Acc_zapisz    (acc_zapisz),
        .FSM_reset_Acc     (reset_acc),
        .FSM_wyj_wr        (wyj_wr),
        .mnozenie_wynik    (mnoz),
        .Petla_full        (petla_full),
        .Licznik_full      (licznik_full),
        .adres_wsp         (adres_wsp),
        .adres_probki      (adres_probki),
        .Acc_out           (acc_out),
        .blad_overrun      (overrun),
        .wyj               (dif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cmds();
        petla_en = 0; reset_petla = 0; nowa_probka = 0; reset_licznik = 0;
        acc_en = 0; acc_zapisz = 0; reset_acc = 0; wyj_wr = 0; mnoz = '0;
    endtask

    task automatic acc_seq(input int v0, input int v1, input int v2, input int v3, input int cnt);
        int vals[4];
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        for (int i = 0; i < cnt; i++) begin
            acc_en = 1; mnoz = 16'(vals[i]);
            tick();
        end
        idle_cmds();
    endtask

    task automatic pulse_zapisz();
        acc_zapisz = 1; tick(); acc_zapisz = 0;
    endtask

    task automatic pulse_wr();
        wyj_wr = 1; tick(); wyj_wr = 0;
    endtask

    task automatic pulse_reset_acc();
        reset_acc = 1; tick(); reset_acc = 0;
    endtask

    initial begin
        idle_cmds();
        dif.wyj_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_adres_wsp", int'(adres_wsp), 0);
        check("rst_petla_full", int'(petla_full), 0);
        check("rst_licznik_full", int'(licznik_full), 0);
        check("rst_acc", int'(acc_out), 0);
        check("rst_valid", int'(dif.wyj_valid), 0);
        check("rst_overrun", int'(overrun), 0);

        petla_en = 1; tick(15);
        check("petla_15", int'(adres_wsp), 15);
        check("petla_full", int'(petla_full), 1);
        tick();
        check("petla_hold", int'(adres_wsp), 15);
        reset_petla = 1; tick(); idle_cmds();
        check("petla_clr", int'(adres_wsp), 0);
        check("petla_full_clr", int'(petla_full), 0);

        acc_en = 1; mnoz = 16'sd100; tick();
        check("acc_latency", int'(acc_out), 100);
        idle_cmds();
        acc_seq(50, -30, 7, 0, 3);
        check("acc_127", int'(acc_out), 127);
        pulse_zapisz();
        pulse_wr();
        check("out_valid_127", int'(dif.wyj_valid), 1);
        check("out_dane_127", int'(dif.wyj_dane), 127);
        tick();
        check("out_valid_drop", int'(dif.wyj_valid), 0);

        pulse_reset_acc();
        acc_seq(32767, 32767, 32767, 0, 3);
        check("acc_98301", int'(acc_out), 98301);
        acc_zapisz = 1; wyj_wr = 1; tick(); idle_cmds();
        check("zap_wr_same_old", int'(dif.wyj_dane), 127);
        tick();
        pulse_wr();
        check("sat_pos", int'(dif.wyj_dane), 32767);
        tick();

        pulse_reset_acc();
        acc_seq(-32768, -32768, -32768, 0, 3);
        check("acc_neg", int'(acc_out), -98304);
        pulse_zapisz();
        pulse_wr();
        check("sat_neg", int'(dif.wyj_dane), -32768);
        tick();

        pulse_reset_acc();
        acc_seq(5, 0, 0, 0, 1);
        pulse_zapisz();
        dif.wyj_ready = 1'b0;
        pulse_wr();
        check("ovr_valid1", int'(dif.wyj_valid), 1);
        acc_seq(1, 0, 0, 0, 1);
        pulse_zapisz();
        pulse_wr();
        check("ovr_flag", int'(overrun), 1);
        check("ovr_valid2", int'(dif.wyj_valid), 1);
        check("ovr_data_held", int'(dif.wyj_dane), 5);
        dif.wyj_ready = 1'b1;
        tick();
        check("ovr_drain", int'(dif.wyj_valid), 0);
        check("ovr_sticky", int'(overrun), 1);

        nowa_probka = 1; tick(10); idle_cmds();
        check("probka_10", int'(adres_probki), 10);
        pulse_zapisz();
        pulse_wr();
        check("wyj_adres_10", int'(dif.wyj_adres), 10);
        tick();
        nowa_probka = 1; tick(53);
        check("probka_63", int'(adres_probki), 63);
        check("licznik_full", int'(licznik_full), 1);
        tick();
        idle_cmds();
        check("probka_hold", int'(adres_probki), 63);

        petla_en = 1; tick(3); idle_cmds();
        acc_seq(9, 0, 0, 0, 1);
        dif.wyj_ready = 1'b0;
        pulse_wr();
        check("pre_rst_valid", int'(dif.wyj_valid), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        dif.wyj_ready = 1'b1;
        check("mid_rst_valid", int'(dif.wyj_valid), 0);
        check("mid_rst_acc", int'(acc_out), 0);
        check("mid_rst_wsp", int'(adres_wsp), 0);
        check("mid_rst_probki", int'(adres_probki), 0);
        check("mid_rst_dane", int'(dif.wyj_dane), 0);
        check("mid_rst_adres", int'(dif.wyj_adres), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_lfull", int'(licznik_full), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
